// File: rtl/mrr_fft_norm_pingpong_if.sv
// Magnitude-stream / exponent-readout bundle for mrr_fft_norm_pingpong.
// master: upstream source + normaliser; slave: exponent tracker.
interface mrr_fft_norm_pingpong_if #(
    parameter int NUM_CH       = 1,
    parameter int MAG_W        = 32,
    parameter int PRI_MAX_LOG2 = 10
);
    localparam int SHIFT_W = $clog2(MAG_W);

    logic [NUM_CH*MAG_W-1:0] in_mag;
    logic                    in_valid;
    logic                    in_ready;
    logic                    frame_done;
    logic                    out_avail;
    logic                    out_req;
    logic [PRI_MAX_LOG2-1:0] out_idx;
    logic [SHIFT_W-1:0]      out_shift;
    logic                    out_shift_valid;
    logic                    out_release;

    modport master (
        output in_mag, in_valid, out_req, out_idx, out_release,
        input  in_ready, frame_done, out_avail, out_shift, out_shift_valid
    );

    modport slave (
        input  in_mag, in_valid, out_req, out_idx, out_release,
        output in_ready, frame_done, out_avail, out_shift, out_shift_valid
    );
endinterface

// File: rtl/mrr_fft_norm_pingpong.sv
// Per-primary-bin block-floating-point exponent tracker with a
// two-bank ping-pong result store for the 2-D CFO/SFO FFT stream.
// Ports: clk, rst_n (async, active low), clear (sync soft reset),
//   setting_pri_len_log2 / setting_sec_len_log2 (latched per frame),
//   bus (slave): in_mag/in_valid/in_ready stream in, frame_done,
//   out_avail/out_req/out_idx/out_shift/out_shift_valid/out_release.
// Option MRR_NORM_SHIFT_OFFSET_EN: adds setting_target_msb and
//   returns the stored msb minus the target, saturated at zero.
module mrr_fft_norm_pingpong #(
    parameter int  NUM_CH       = 1,
    parameter int  MAG_W        = 32,
    parameter int  PRI_MAX_LOG2 = 10,
    parameter int  SEC_MAX_LOG2 = 6,
    localparam int SHIFT_W      = $clog2(MAG_W),
    localparam int PL_W         = $clog2(PRI_MAX_LOG2 + 1),
    localparam int SL_W         = $clog2(SEC_MAX_LOG2 + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [PL_W-1:0]    setting_pri_len_log2,
    input  logic [SL_W-1:0]    setting_sec_len_log2,
`ifdef MRR_NORM_SHIFT_OFFSET_EN
    input  logic [SHIFT_W-1:0] setting_target_msb,
`endif
    mrr_fft_norm_pingpong_if.slave bus
);
    localparam int IDX_W = PRI_MAX_LOG2 + SEC_MAX_LOG2;
    localparam int SUM_W = $clog2(IDX_W + 1);
    localparam int DEPTH = 1 << PRI_MAX_LOG2;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_st_t;

    bank_st_t                st [2];
    logic                    fill_bank;
    logic                    rd_bank;
    logic [IDX_W-1:0]        in_idx;
    logic [PL_W-1:0]         pl_q;
    logic [SL_W-1:0]         sl_q;
    logic [PL_W-1:0]         bank_pl [2];
    logic [SHIFT_W-1:0]      mem [2*DEPTH];

    logic                    s1_valid;
    logic                    s1_first;
    logic                    s1_bank;
    logic [PRI_MAX_LOG2-1:0] s1_bin;
    logic [SHIFT_W-1:0]      s1_msb;
    logic [SHIFT_W-1:0]      s1_rd;

    logic                    frame_done_q;
    logic [SHIFT_W-1:0]      out_shift_q;
    logic                    out_shift_valid_q;

    logic                    in_ready;
    logic                    acc;
    logic                    frame_start;
    logic                    first;
    logic                    last;
    logic                    fwd;
    logic                    out_avail;
    logic                    rd_ok;
    logic                    rel;
    logic [PL_W-1:0]         pl_eff;
    logic [SL_W-1:0]         sl_eff;
    logic [IDX_W-1:0]        pri_mask;
    logic [IDX_W-1:0]        frame_mask;
    logic [PRI_MAX_LOG2-1:0] bin;
    logic [PRI_MAX_LOG2-1:0] out_mask;
    logic [SHIFT_W-1:0]      msb;
    logic [SHIFT_W-1:0]      wr_val;
    logic [SHIFT_W-1:0]      rd_val;
    logic [SHIFT_W-1:0]      shift_val;

    function automatic logic [SHIFT_W-1:0] msb_of(
        input logic [NUM_CH*MAG_W-1:0] v
    );
        logic [MAG_W-1:0]   m;
        logic [SHIFT_W-1:0] r;
        m = '0;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (v[c*MAG_W +: MAG_W] > m) m = v[c*MAG_W +: MAG_W];
        end
        for (int i = 0; i < MAG_W; i++) begin
            if (m[i]) r = SHIFT_W'(i);
        end
        return r;
    endfunction

    assign in_ready    = (st[fill_bank] == EMPTY) ||
                         (st[fill_bank] == FILLING);
    assign acc         = bus.in_valid && in_ready;
    assign frame_start = (in_idx == '0);

    // First beat of a frame uses the live settings; later beats the latched copy.
    assign pl_eff     = frame_start ? setting_pri_len_log2 : pl_q;
    assign sl_eff     = frame_start ? setting_sec_len_log2 : sl_q;
    assign pri_mask   = ~({IDX_W{1'b1}} << pl_eff);
    assign frame_mask = ~({IDX_W{1'b1}} << (SUM_W'(pl_eff) + SUM_W'(sl_eff)));
    assign bin        = PRI_MAX_LOG2'(in_idx & pri_mask);
    assign first      = ((in_idx & ~pri_mask) == '0);
    assign last       = (in_idx == frame_mask);
    assign msb        = msb_of(bus.in_mag);

    assign wr_val = (s1_first || (s1_msb > s1_rd)) ? s1_msb : s1_rd;

    // The write of the previous beat lands on the same edge as this read.
    assign fwd = s1_valid && (s1_bank == fill_bank) && (s1_bin == bin);

    assign out_avail = (st[rd_bank] == READING);
    assign rd_ok     = bus.out_req && out_avail;
    assign rel       = bus.out_release && out_avail;
    assign out_mask  = ~({PRI_MAX_LOG2{1'b1}} << bank_pl[rd_bank]);
    assign rd_val    = mem[{rd_bank, bus.out_idx & out_mask}];

`ifdef MRR_NORM_SHIFT_OFFSET_EN
    assign shift_val = (rd_val > setting_target_msb) ?
                       (rd_val - setting_target_msb) : '0;
`else
    assign shift_val = rd_val;
`endif

    assign bus.in_ready        = in_ready;
    assign bus.frame_done      = frame_done_q;
    assign bus.out_avail       = out_avail;
    assign bus.out_shift       = out_shift_q;
    assign bus.out_shift_valid = out_shift_valid_q;

    always_ff @(posedge clk) begin
        if (s1_valid) mem[{s1_bank, s1_bin}] <= wr_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st[0]             <= EMPTY;
            st[1]             <= EMPTY;
            fill_bank         <= 1'b0;
            rd_bank           <= 1'b0;
            in_idx            <= '0;
            pl_q              <= '0;
            sl_q              <= '0;
            bank_pl[0]        <= '0;
            bank_pl[1]        <= '0;
            s1_valid          <= 1'b0;
            s1_first          <= 1'b0;
            s1_bank           <= 1'b0;
            s1_bin            <= '0;
            s1_msb            <= '0;
            s1_rd             <= '0;
            frame_done_q      <= 1'b0;
            out_shift_q       <= '0;
            out_shift_valid_q <= 1'b0;
        end else if (clear) begin
            st[0]             <= EMPTY;
            st[1]             <= EMPTY;
            fill_bank         <= 1'b0;
            rd_bank           <= 1'b0;
            in_idx            <= '0;
            s1_valid          <= 1'b0;
            frame_done_q      <= 1'b0;
            out_shift_q       <= '0;
            out_shift_valid_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            s1_valid     <= acc;
            if (acc) begin
                s1_bin   <= bin;
                s1_first <= first;
                s1_bank  <= fill_bank;
                s1_msb   <= msb;
                s1_rd    <= fwd ? wr_val : mem[{fill_bank, bin}];
                if (frame_start) begin
                    pl_q <= setting_pri_len_log2;
                    sl_q <= setting_sec_len_log2;
                end
                if (last) begin
                    in_idx             <= '0;
                    fill_bank          <= ~fill_bank;
                    frame_done_q       <= 1'b1;
                    bank_pl[fill_bank] <= pl_eff;
                end else begin
                    in_idx <= in_idx + IDX_W'(1);
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (acc && last && (fill_bank == 1'(b))) begin
                    st[b] <= FULL;
                end else if (acc && (fill_bank == 1'(b)) && (st[b] == EMPTY)) begin
                    st[b] <= FILLING;
                end else if (rel && (rd_bank == 1'(b))) begin
                    st[b] <= EMPTY;
                end else if ((rd_bank == 1'(b)) && (st[b] == FULL)) begin
                    st[b] <= READING;
                end
            end
            if (rel) rd_bank <= ~rd_bank;
            out_shift_valid_q <= rd_ok;
            if (rd_ok) out_shift_q <= shift_val;
        end
    end
endmodule
